// File: rtl/expand.sv
// expand: widens signed image words to the number domain by sign extension and a per-word left
// shift, behind a 2-stage valid/ready pipeline. Define EXPAND_SATURATE_EN to saturate overflow.
module expand #(
  parameter int unsigned NUM_WIDTH  = 33,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned NUM_AWIDTH = $clog2(NUM_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           shift,
  input  logic                 up_val,
  output logic                 up_rdy,
  input  logic [IMG_WIDTH-1:0] up_data,
  output logic                 dn_val,
  input  logic                 dn_rdy,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_sat
);

  localparam logic [7:0] ShiftLimit = 8'(NUM_WIDTH);

  logic                        en;
  logic                        v1_q, v1_d;
  logic signed [NUM_WIDTH-1:0] d1_q, d1_d;
  logic [7:0]                  s1_q, s1_d;
  logic                        v2_q, v2_d;
  logic [NUM_WIDTH-1:0]        dn_data_q, dn_data_d;

  logic [NUM_AWIDTH-1:0]       sh_amt;
  logic                        big_shift;
  logic signed [NUM_WIDTH-1:0] shifted;
  logic [NUM_WIDTH-1:0]        res_data;

  assign en     = ~v2_q | dn_rdy;
  assign up_rdy = en;
  assign dn_val = v2_q;
  assign dn_data = dn_data_q;

  // Stage 1 capture; stage registers hold as a whole when the output is stalled.
  always_comb begin
    v1_d = v1_q;
    d1_d = d1_q;
    s1_d = s1_q;
    v2_d = v2_q;
    if (en) begin
      v1_d = up_val;
      d1_d = {{(NUM_WIDTH - IMG_WIDTH){up_data[IMG_WIDTH-1]}}, up_data};
      s1_d = shift;
      v2_d = v1_q;
    end
  end

  // Only the low bits matter when the shift is below NUM_WIDTH; larger shifts are handled apart.
  assign sh_amt    = s1_q[NUM_AWIDTH-1:0];
  assign big_shift = (s1_q >= ShiftLimit);
  assign shifted   = d1_q <<< sh_amt;

`ifdef EXPAND_SATURATE_EN
  logic signed [NUM_WIDTH-1:0] back;
  logic                        fits;
  logic                        sat_d, dn_sat_q;

  // The shift lost no information iff shifting back reproduces the operand.
  assign back = shifted >>> sh_amt;

  always_comb begin
    fits = (d1_q == '0) || (!big_shift && (back == d1_q));
    if (fits) begin
      res_data = big_shift ? '0 : shifted;
      sat_d    = 1'b0;
    end else begin
      res_data = d1_q[NUM_WIDTH-1] ? {1'b1, {(NUM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(NUM_WIDTH-1){1'b1}}};
      sat_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_sat_q <= 1'b0;
    end else if (en) begin
      dn_sat_q <= sat_d;
    end
  end

  assign dn_sat = dn_sat_q;
`else
  assign res_data = big_shift ? '0 : shifted;
  assign dn_sat   = 1'b0;
`endif

  assign dn_data_d = en ? res_data : dn_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      d1_q      <= '0;
      s1_q      <= '0;
      v2_q      <= 1'b0;
      dn_data_q <= '0;
    end else begin
      v1_q      <= v1_d;
      d1_q      <= d1_d;
      s1_q      <= s1_d;
      v2_q      <= v2_d;
      dn_data_q <= dn_data_d;
    end
  end

endmodule
